// File: rtl/wb_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_copy_master
// Purpose  : Wishbone initiator that copies len_i 32-bit words from src_i to
//            dst_i. Each word is one single read cycle followed by one single
//            write cycle, with a mandatory one-clock cyc_o=0 gap after every
//            bus cycle.
// Ports    : clk_i/rst_i      clock, asynchronous active-high reset
//            start_i          start request, sampled only while idle
//            src_i/dst_i      byte addresses (bits [1:0] forced to 0)
//            len_i            word count; 0 gives a done_o pulse, no bus cycles
//            busy_o/done_o    transfer in progress / one-cycle completion pulse
//            err_o            sticky abort flag (timeout build only)
//            cyc_o..dat_o     Wishbone master outputs; dat_i/ack_i inputs
// Options  : define WB_TIMEOUT_EN to abort a bus cycle that sees no ack_i
//            within TO_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module wb_copy_master #(
    parameter int LENW      = 12,
    parameter int TO_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [31:0]     src_i,
    input  logic [31:0]     dst_i,
    input  logic [LENW-1:0] len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [3:0]      sel_o,
    output logic [31:0]     adr_o,
    output logic [31:0]     dat_o,
    input  logic [31:0]     dat_i,
    input  logic            ack_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RGAP = 3'd2,
        S_WR   = 3'd3,
        S_WGAP = 3'd4
    } state_t;

    state_t          r_state;
    logic [31:0]     r_src;
    logic [31:0]     r_dst;
    logic [31:0]     r_hold;
    logic [31:0]     r_adr;
    logic [31:0]     r_dat;
    logic [LENW-1:0] r_count;
    logic            r_busy;
    logic            r_done;
    logic            r_cyc;
    logic            r_we;
    logic [3:0]      r_sel;

`ifdef WB_TIMEOUT_EN
    // Counter holds the number of ack-less clocks already spent in the
    // current cycle, so the abort fires on the TO_CYCLES-th such clock.
    localparam int TOW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYCLES - 1);
    logic [TOW-1:0] r_to_cnt;
    logic           r_err;
`endif

    // Address bits [1:0] are ignored by design.
    logic w_unused;
    assign w_unused = ^{src_i[1:0], dst_i[1:0], (TO_CYCLES > 0)};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_hold   <= '0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= 4'h0;
`ifdef WB_TIMEOUT_EN
            r_to_cnt <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
`ifdef WB_TIMEOUT_EN
                        r_err <= 1'b0;
`endif
                        if (len_i != '0) begin
                            r_src   <= {src_i[31:2], 2'b00};
                            r_dst   <= {dst_i[31:2], 2'b00};
                            r_count <= len_i;
                            r_busy  <= 1'b1;
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b0;
                            r_sel   <= 4'hF;
                            r_adr   <= {src_i[31:2], 2'b00};
                            r_state <= S_RD;
`ifdef WB_TIMEOUT_EN
                            r_to_cnt <= '0;
`endif
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (ack_i) begin
                        r_hold  <= dat_i;
                        r_cyc   <= 1'b0;
                        r_sel   <= 4'h0;
                        r_state <= S_RGAP;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_cyc   <= 1'b0;
                        r_sel   <= 4'h0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TOW'(1);
                    end
`endif
                end
                S_RGAP: begin
                    r_cyc   <= 1'b1;
                    r_we    <= 1'b1;
                    r_sel   <= 4'hF;
                    r_adr   <= r_dst;
                    r_dat   <= r_hold;
                    r_state <= S_WR;
`ifdef WB_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                S_WR: begin
                    if (ack_i) begin
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_sel   <= 4'h0;
                        r_state <= S_WGAP;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_sel   <= 4'h0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TOW'(1);
                    end
`endif
                end
                S_WGAP: begin
                    // Addresses wrap modulo 2**32 without any error.
                    r_src   <= r_src + 32'd4;
                    r_dst   <= r_dst + 32'd4;
                    r_count <= r_count - LENW'(1);
                    if (r_count == LENW'(1)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cyc   <= 1'b1;
                        r_sel   <= 4'hF;
                        r_adr   <= r_src + 32'd4;
                        r_state <= S_RD;
`ifdef WB_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign cyc_o  = r_cyc;
    assign stb_o  = r_cyc;
    assign we_o   = r_we;
    assign sel_o  = r_sel;
    assign adr_o  = r_adr;
    assign dat_o  = r_dat;
`ifdef WB_TIMEOUT_EN
    assign err_o  = r_err;
`else
    assign err_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/wb_copy_master.md
Name: wb_copy_master

Overview:
Wishbone bus initiator that copies a block of 32-bit words from a source address range to a destination address range. For each word it performs one single read cycle, then one single write cycle. It is the master-side counterpart to the team's Wishbone scratch RAMs and peripherals, and sits between a control register block (start/src/dst/len) and the system Wishbone bus. It is intended for memory initialisation, block moves and bus soak tests.

Parameters:
LENW, 12, width of word-count input; max transfer is 2**LENW-1 words
TO_CYCLES, 255, ack timeout in clocks; used only when WB_TIMEOUT_EN is defined

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
start_i  input  1  single-cycle start request; sampled only in IDLE
src_i  input  32  source byte address; bits [1:0] ignored (forced 0)
dst_i  input  32  destination byte address; bits [1:0] ignored (forced 0)
len_i  input  LENW  number of 32-bit words to copy
busy_o  output  1  high from the cycle after an accepted start until return to IDLE
done_o  output  1  one-cycle pulse when a transfer completes or aborts
err_o  output  1  sticky abort flag; cleared by the next accepted start
cyc_o  output  1  Wishbone cycle
stb_o  output  1  Wishbone strobe (always equal to cyc_o)
we_o  output  1  Wishbone write enable
sel_o  output  4  byte selects; always 4'hF during a cycle, 4'h0 otherwise
adr_o  output  32  Wishbone byte address
dat_o  output  32  Wishbone write data
dat_i  input  32  Wishbone read data
ack_i  input  1  Wishbone acknowledge

Behaviour:
- Reset (async, active-high): state IDLE; cyc_o/stb_o/we_o/busy_o/done_o/err_o = 0; sel_o = 0; adr_o = 0; dat_o = 0; internal src/dst/count/hold registers = 0.
- Reset asserted mid-transfer drops cyc_o/stb_o immediately, not at the next edge. The transfer is abandoned with no done_o pulse.
- States: IDLE, RD, RGAP, WR, WGAP. All outputs are registered.
- IDLE:
  - start_i=1 and len_i!=0: latch src/dst (with [1:0]=0) and count=len_i; clear err_o; set busy_o; go to RD.
  - start_i=1 and len_i==0: no bus activity; pulse done_o next cycle; busy_o stays 0.
- start_i outside IDLE is ignored, and no queued restart is recorded.
- RD: cyc_o=stb_o=1, we_o=0, adr_o=src.
  - ack_i may arrive in the first cycle of stb_o or any later cycle.
  - On the ack_i cycle, capture dat_i into the hold register, then go to RGAP.
- RGAP: cyc_o=stb_o=0 for exactly one clock, then WR. The mandatory gap keeps slaves with a registered ack from being seen as acking the next cycle.
- WR: cyc_o=stb_o=1, we_o=1, adr_o=dst, dat_o=hold.
  - ack_i may arrive in the first cycle of stb_o or later.
  - On ack go to WGAP.
- WGAP: cyc_o=0; src+=4, dst+=4, count-=1.
  - New count==0: go to IDLE, pulse done_o, drop busy_o.
  - Otherwise go to RD.
- ack_i while cyc_o=0 is ignored.
- Minimum throughput: 4 clocks per word with zero-wait slaves.
- Address arithmetic is modulo 2**32: dst or src of 32'hFFFFFFFC increments to 32'h0. No error is flagged.
- Overlapping src/dst ranges are copied in ascending order with no hazard protection.

Optional Feature:
Macro WB_TIMEOUT_EN.
- Defined: a counter runs while in RD or WR without ack_i and resets on each entry to RD/WR.
  - When it reaches TO_CYCLES with no ack: drop cyc_o/stb_o, go to IDLE, set err_o=1, pulse done_o, drop busy_o.
  - An ack in the same cycle the counter hits TO_CYCLES wins; no abort occurs.
- Undefined: no counter; the block waits indefinitely for ack_i; err_o is tied 0.

Test Plan:
- src=0x100, dst=0x200, len=3; slave acks reads 1 cycle late and writes in the same cycle -> three read/write pairs at 0x100/0x200, 0x104/0x204, 0x108/0x208. Destination data matches source. Each cycle is separated by one cyc_o=0 clock. A single done_o pulse occurs; err_o=0.
- len=0 with start -> no cyc_o activity, busy_o stays 0, done_o pulses once.
- start pulsed again during word 2 of a len=4 copy -> ignored; exactly 4 words are copied and one done_o pulse occurs.
- rst_i asserted asynchronously while in WR with cyc_o=1 -> cyc_o/stb_o/busy_o fall before the next clk_i edge. No done_o pulse. After reset release, a new start operates normally.
- Slave stalls ack for 10 clocks on a read -> hold is captured only on the ack cycle and the write data is correct.
- With WB_TIMEOUT_EN and TO_CYCLES=8, slave never acks -> abort exactly 8 clocks after stb_o rises: err_o=1, done_o pulse, cyc_o=0. The next start clears err_o.
